// File: rtl/powlib_sfifo_ext_pkg.sv
// Shared helpers for the extended synchronous FIFO.
package powlib_sfifo_ext_pkg;

    // ceil(log2(v)), never less than 1
    function automatic int unsigned powlib_clogb2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/powlib_sfifo_ext_oreg.sv
// Single-entry valid/data output register with load/unload handshake.
module powlib_sfifo_ext_oreg
    import powlib_sfifo_ext_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] lddata,
    input  logic         unld,
    output logic         vld,
    output logic [W-1:0] data
);

    logic         vld_q;
    logic [W-1:0] data_q;

    // Load wins over unload so a consumed slot can be refilled in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vld_q <= 1'b0;
        end else if (ld) begin
            vld_q <= 1'b1;
        end else if (unld) begin
            vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ld) begin
            data_q <= lddata;
        end
    end

    assign vld  = vld_q;
    assign data = data_q;

endmodule

// File: rtl/powlib_sfifo_ext.sv
// Single-clock valid/ready FIFO of any depth with occupancy count, registered
// almost-full/almost-empty flags, synchronous flush and optional output register.
module powlib_sfifo_ext
    import powlib_sfifo_ext_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned D     = 8,
    parameter int unsigned EOREG = 0,
    parameter int unsigned AFT   = D - 1,
    parameter int unsigned AET   = 1,
    parameter int unsigned EDBG  = 0,
    parameter string       ID    = "SFIFOX",
    localparam int unsigned WC   = powlib_clogb2(D + EOREG + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [W-1:0]  wrdata,
    input  logic          wrvld,
    output logic          wrrdy,
    output logic [W-1:0]  rddata,
    output logic          rdvld,
    input  logic          rdrdy,
    output logic [WC-1:0] count,
    output logic          afull,
    output logic          aempty
);

    localparam int unsigned CAP = D + EOREG;
    localparam int unsigned WP  = powlib_clogb2(D);

    if (EDBG != 0) begin : g_dbg
        if (D < 2 || AFT > CAP || AET >= CAP) begin : g_bad
            $error("%s: illegal FIFO parameters", ID);
        end
    end

    logic [WC-1:0] count_q, count_d;
    logic [WP-1:0] wrptr_q, rdptr_q;
    logic          afull_q, aempty_q;
    logic          wrinc, rdinc;
    logic          ramwe, ramre;
    logic [W-1:0]  ramrd;
    logic [W-1:0]  mem [D];

    // Ready depends only on registered state, so a full FIFO never writes through.
    assign wrrdy = !rst && !flush && (count_q != WC'(CAP));
    assign wrinc = wrvld && wrrdy;
    assign rdinc = rdvld && rdrdy;
    assign ramrd = mem[rdptr_q];

    if (EOREG != 0) begin : g_oreg
        logic          slotvld;
        logic          bypass;
        logic          ld;
        logic [WC-1:0] ramcnt;
        logic [W-1:0]  lddata;

        assign ramcnt = count_q - WC'(slotvld);
        // With nothing queued in RAM the write goes straight into a free slot.
        assign bypass = wrinc && (ramcnt == '0) && (!slotvld || rdinc);
        assign ramre  = (ramcnt != '0) && (!slotvld || rdinc);
        assign ramwe  = wrinc && !bypass;
        assign ld     = bypass || ramre;
        assign lddata = bypass ? wrdata : ramrd;
        assign rdvld  = !rst && slotvld;

        powlib_sfifo_ext_oreg #(
            .W (W)
        ) u_oreg (
            .clk    (clk),
            .rst    (rst),
            .clr    (flush),
            .ld     (ld),
            .lddata (lddata),
            .unld   (rdinc),
            .vld    (slotvld),
            .data   (rddata)
        );
    end else begin : g_noreg
        assign ramre  = rdinc;
        assign ramwe  = wrinc;
        assign rdvld  = !rst && (count_q != '0);
        assign rddata = ramrd;
    end

    always_comb begin
        count_d = count_q;
        if (wrinc && !rdinc) begin
            count_d = count_q + WC'(1);
        end else if (!wrinc && rdinc) begin
            count_d = count_q - WC'(1);
        end
        if (rst || flush) begin
            count_d = '0;
        end
    end

    // Flags follow count_d so they always agree with count in the same cycle.
    always_ff @(posedge clk) begin
        count_q  <= count_d;
        afull_q  <= (32'(count_d) >= AFT);
        aempty_q <= (32'(count_d) <= AET);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wrptr_q <= '0;
            rdptr_q <= '0;
        end else begin
            if (ramwe) begin
                wrptr_q <= (wrptr_q == WP'(D - 1)) ? '0 : wrptr_q + WP'(1);
            end
            if (ramre) begin
                rdptr_q <= (rdptr_q == WP'(D - 1)) ? '0 : rdptr_q + WP'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ramwe) begin
            mem[wrptr_q] <= wrdata;
        end
    end

    assign count  = count_q;
    assign afull  = afull_q;
    assign aempty = aempty_q;

endmodule
